// File: rtl/sdram_port_arbiter_if.sv
// Avalon-MM master bus toward the SDRAM controller interface_* slave port.
// master: arbiter drives address/byteenable_n/chipselect/writedata/read_n/write_n,
//         receives readdata/readdatavalid/waitrequest.  slave: controller side.
interface sdram_port_arbiter_if #(
   parameter int ADDR_W = 25,
   parameter int DATA_W = 16
);
   localparam int BE_W = DATA_W / 8;

   logic [ADDR_W-1:0] interface_address;
   logic [BE_W-1:0]   interface_byteenable_n;
   logic              interface_chipselect;
   logic [DATA_W-1:0] interface_writedata;
   logic              interface_read_n;
   logic              interface_write_n;
   logic [DATA_W-1:0] interface_readdata;
   logic              interface_readdatavalid;
   logic              interface_waitrequest;

   modport master (
      output interface_address, interface_byteenable_n,
      output interface_chipselect, interface_writedata,
      output interface_read_n, interface_write_n,
      input  interface_readdata, interface_readdatavalid,
      input  interface_waitrequest
   );

   modport slave (
      input  interface_address, interface_byteenable_n,
      input  interface_chipselect, interface_writedata,
      input  interface_read_n, interface_write_n,
      output interface_readdata, interface_readdatavalid,
      output interface_waitrequest
   );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Round-robin N-port Avalon-MM arbiter in front of the SDRAM controller.
// Ports: clk_clk/reset_reset; port_* requester side (packed per port);
// bus = controller master interface; pending_count, err_orphan status.
module sdram_port_arbiter #(
   parameter int NUM_PORTS   = 3,
   parameter int ADDR_W      = 25,
   parameter int DATA_W      = 16,
   parameter int MAX_PENDING = 8
) (
   input  logic                          clk_clk,
   input  logic                          reset_reset,
   input  logic [NUM_PORTS*ADDR_W-1:0]   port_address,
   input  logic [NUM_PORTS-1:0]          port_read,
   input  logic [NUM_PORTS-1:0]          port_write,
   input  logic [NUM_PORTS*DATA_W-1:0]   port_writedata,
   input  logic [NUM_PORTS*DATA_W/8-1:0] port_byteenable,
   output logic [NUM_PORTS-1:0]          port_waitrequest,
   output logic [DATA_W-1:0]             port_readdata,
   output logic [NUM_PORTS-1:0]          port_readdatavalid,
   sdram_port_arbiter_if.master          bus,
   output logic [$clog2(MAX_PENDING):0]  pending_count,
   output logic                          err_orphan
);
   localparam int BE_W = DATA_W / 8;
   localparam int PW   = $clog2(NUM_PORTS);
   localparam int FW   = $clog2(MAX_PENDING);
   localparam int CW   = FW + 1;

   typedef enum logic {IDLE, ISSUE} state_t;

   state_t            state_q, state_d;
   logic [PW-1:0]     last_q, last_d;
   logic [PW-1:0]     grant_q, grant_d;
   logic              rd_q, rd_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [BE_W-1:0]   be_n_q, be_n_d;
   logic              cs_q, cs_d;
   logic              rd_n_q, rd_n_d;
   logic              wr_n_q, wr_n_d;

   logic [PW-1:0]     tag_mem [MAX_PENDING];
   logic [FW-1:0]     wptr_q, rptr_q;
   logic [CW-1:0]     count_q;
   logic [DATA_W-1:0] rdata_q;
   logic [NUM_PORTS-1:0] rvalid_q;
   logic              orphan_q;

   logic [NUM_PORTS-1:0] elig;
   logic              full, found, accept, push, pop, is_wr;
   logic [PW-1:0]     win, idx_c;

   assign full   = (count_q == CW'(MAX_PENDING));
   assign accept = (state_q == ISSUE) && !bus.interface_waitrequest;
   assign push   = accept && rd_q;
   assign pop    = bus.interface_readdatavalid && (count_q != '0);

   // Writes never wait on the tag FIFO; only reads are held off when full.
   assign elig = port_write | (port_read & {NUM_PORTS{~full}});

   // Search starts one past the last winner so every requester is reached.
   always_comb begin
      found = 1'b0;
      win   = '0;
      idx_c = '0;
      for (int k = 1; k <= NUM_PORTS; k++) begin
         idx_c = PW'((int'(last_q) + k) % NUM_PORTS);
         if (!found && elig[idx_c]) begin
            found = 1'b1;
            win   = idx_c;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      grant_d = grant_q;
      rd_d    = rd_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      be_n_d  = be_n_q;
      cs_d    = cs_q;
      rd_n_d  = rd_n_q;
      wr_n_d  = wr_n_q;
      is_wr   = port_write[win];
      unique case (state_q)
         IDLE: begin
            if (found) begin
               state_d = ISSUE;
               last_d  = win;
               grant_d = win;
               rd_d    = ~is_wr;
               addr_d  = port_address[win*ADDR_W +: ADDR_W];
               wdata_d = port_writedata[win*DATA_W +: DATA_W];
               be_n_d  = ~port_byteenable[win*BE_W +: BE_W];
               cs_d    = 1'b1;
               rd_n_d  = is_wr;
               wr_n_d  = ~is_wr;
            end
         end
         ISSUE: begin
            if (accept) begin
               state_d = IDLE;
               cs_d    = 1'b0;
               rd_n_d  = 1'b1;
               wr_n_d  = 1'b1;
               be_n_d  = '1;
            end
         end
      endcase
   end

   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         state_q <= IDLE;
         last_q  <= PW'(NUM_PORTS - 1);
         grant_q <= '0;
         rd_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_n_q  <= '1;
         cs_q    <= 1'b0;
         rd_n_q  <= 1'b1;
         wr_n_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         grant_q <= grant_d;
         rd_q    <= rd_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         be_n_q  <= be_n_d;
         cs_q    <= cs_d;
         rd_n_q  <= rd_n_d;
         wr_n_q  <= wr_n_d;
      end
   end

   // A read is granted only when not full, and occupancy cannot grow
   // between grant and acceptance, so a push never overflows.
   always_ff @(posedge clk_clk) begin
      if (push) tag_mem[wptr_q] <= grant_q;
   end

   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         wptr_q   <= '0;
         rptr_q   <= '0;
         count_q  <= '0;
         rdata_q  <= '0;
         rvalid_q <= '0;
         orphan_q <= 1'b0;
      end else begin
         if (push) wptr_q <= wptr_q + 1'b1;
         if (pop)  rptr_q <= rptr_q + 1'b1;
         count_q  <= count_q + CW'(push) - CW'(pop);
         rvalid_q <= pop ? (NUM_PORTS'(1) << tag_mem[rptr_q]) : '0;
         if (pop) rdata_q <= bus.interface_readdata;
         if (bus.interface_readdatavalid && count_q == '0) orphan_q <= 1'b1;
      end
   end

   assign port_waitrequest   = ~(accept ? (NUM_PORTS'(1) << grant_q) : '0);
   assign port_readdata      = rdata_q;
   assign port_readdatavalid = rvalid_q;
   assign pending_count      = count_q;
   assign err_orphan         = orphan_q;

   assign bus.interface_address      = addr_q;
   assign bus.interface_byteenable_n = be_n_q;
   assign bus.interface_chipselect   = cs_q;
   assign bus.interface_writedata    = wdata_q;
   assign bus.interface_read_n       = rd_n_q;
   assign bus.interface_write_n      = wr_n_q;
endmodule
